// File: rtl/xalu_ise_issue_pkg.sv
// xalu_ise_issue_pkg -- shared definitions for the xalu_ise issue/writeback stage.
//   OPC_CUSTOM0..3 : RV32 custom opcode encodings (instr[6:0])
//   CUSTOM_0..3    : custom index carried in ise_fn[1:0]
//   state_t        : issue FSM encoding (ST_IDLE / ST_EXEC / ST_RESP)
//   make_fn        : packs the ALU function code {1'b0, funct3, index}
package xalu_ise_issue_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;
    localparam logic [6:0] OPC_CUSTOM2 = 7'b1011011;
    localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;

    localparam logic [1:0] CUSTOM_0 = 2'd0;
    localparam logic [1:0] CUSTOM_1 = 2'd1;
    localparam logic [1:0] CUSTOM_2 = 2'd2;
    localparam logic [1:0] CUSTOM_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [5:0] make_fn(input logic [2:0] funct3, input logic [1:0] idx);
        return {1'b0, funct3, idx};
    endfunction

endpackage

// File: rtl/xalu_ise_issue_if.sv
// xalu_ise_issue_if -- bundles the core request, core writeback response and
// ALU-side signals of the issue stage.
//   slave  : the issue stage (xalu_ise_issue)
//   master : the surrounding core + ALU (or a testbench standing in for them)
interface xalu_ise_issue_if;
    // core request
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    // core writeback response
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_illegal;
    // ALU side
    logic        ise_val;
    logic [5:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1;
    logic [31:0] ise_in2;
    logic        ise_oval;
    logic [31:0] ise_out;

    modport slave (
        input  req_valid, req_instr, req_rs1, req_rs2, rsp_ready, ise_oval, ise_out,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_illegal,
               ise_val, ise_fn, ise_imm, ise_in1, ise_in2
    );

    modport master (
        output req_valid, req_instr, req_rs1, req_rs2, rsp_ready, ise_oval, ise_out,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_illegal,
               ise_val, ise_fn, ise_imm, ise_in1, ise_in2
    );
endinterface

// File: rtl/xalu_ise_issue_dec.sv
// xalu_ise_issue_dec -- combinational opcode decoder.
//   opcode    in  7  instr[6:0]
//   idx       out 2  custom index (0 when not custom)
//   is_custom out 1  opcode is one of custom-0..3
module xalu_ise_issue_dec
    import xalu_ise_issue_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] idx,
    output logic       is_custom
);

    always_comb begin
        idx       = CUSTOM_0;
        is_custom = 1'b1;
        case (opcode)
            OPC_CUSTOM0: idx = CUSTOM_0;
            OPC_CUSTOM1: idx = CUSTOM_1;
            OPC_CUSTOM2: idx = CUSTOM_2;
            OPC_CUSTOM3: idx = CUSTOM_3;
            default:     is_custom = 1'b0;
        endcase
    end

endmodule

// File: rtl/xalu_ise_issue.sv
// xalu_ise_issue -- issue/writeback stage in front of the Alzette/Sparkle
// custom-instruction ALU (xalu_ise, instantiated by the parent).
//   ise_clk, ise_rst : clock, asynchronous active-high reset
//   bus (slave)      : req_* core request, rsp_* writeback response,
//                      ise_* ALU operands/result
//   perf_ops, perf_illegal : saturating handshake counters, present only
//                      when XALU_ISE_ISSUE_PERF_EN is defined
// Parameter EXEC_CYCLES (1..15): cycles ise_val is held before the ALU result
// is sampled.
// Flow: IDLE accepts one request; custom ops spend EXEC_CYCLES in EXEC, others
// go straight to RESP flagged illegal; RESP holds the result until rsp_ready.
module xalu_ise_issue
    import xalu_ise_issue_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic               ise_clk,
    input  logic               ise_rst,
    xalu_ise_issue_if.slave    bus
`ifdef XALU_ISE_ISSUE_PERF_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_illegal
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] in1_q, in2_q, data_q;
    logic [5:0]  fn_q;
    logic [6:0]  imm_q;
    logic [4:0]  rd_q;
    logic        illegal_q;

    logic [1:0]  dec_idx;
    logic        dec_custom;
    logic        accept;
    logic        exec_done;
    logic        rsp_hs;

    // rs1/rs2 register-number fields are resolved by the core, not needed here
    logic        unused_instr;
    assign unused_instr = ^bus.req_instr[24:12];

    xalu_ise_issue_dec u_dec (
        .opcode    (bus.req_instr[6:0]),
        .idx       (dec_idx),
        .is_custom (dec_custom)
    );

    assign accept    = (state_q == ST_IDLE) && bus.req_valid;
    assign exec_done = (state_q == ST_EXEC) && (cnt_q == 4'd0);
    assign rsp_hs    = (state_q == ST_RESP) && bus.rsp_ready;

    // state register
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) state_d = dec_custom ? ST_EXEC : ST_RESP;
            ST_EXEC: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.ise_val   = 1'b0;
        case (state_q)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_EXEC: bus.ise_val   = 1'b1;
            ST_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // operand latch, exec countdown and result capture
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            cnt_q     <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            fn_q      <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            in1_q  <= bus.req_rs1;
            in2_q  <= bus.req_rs2;
            fn_q   <= make_fn(bus.req_instr[14:12], dec_idx);
            imm_q  <= bus.req_instr[31:25];
            rd_q   <= bus.req_instr[11:7];
            cnt_q  <= CNT_INIT;
            // non-custom ops skip EXEC, so their response is settled here
            data_q    <= '0;
            illegal_q <= ~dec_custom;
        end else if (exec_done) begin
            data_q    <= bus.ise_oval ? bus.ise_out : 32'd0;
            illegal_q <= ~bus.ise_oval;
        end else if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign bus.ise_in1     = in1_q;
    assign bus.ise_in2     = in2_q;
    assign bus.ise_fn      = fn_q;
    assign bus.ise_imm     = imm_q;
    assign bus.rsp_data    = data_q;
    assign bus.rsp_rd      = rd_q;
    assign bus.rsp_illegal = illegal_q;

`ifdef XALU_ISE_ISSUE_PERF_EN
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            perf_ops     <= '0;
            perf_illegal <= '0;
        end else if (rsp_hs) begin
            if (perf_ops != 32'hFFFF_FFFF)
                perf_ops <= perf_ops + 32'd1;
            if (illegal_q && perf_illegal != 32'hFFFF_FFFF)
                perf_illegal <= perf_illegal + 32'd1;
        end
    end
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_xalu_ise_issue.sv
// tb_xalu_ise_issue -- directed self-checking bench.
// dut1 (EXEC_CYCLES=1) is attached to a small rotate-right ALU stand-in;
// dut3 (EXEC_CYCLES=3) has its ALU result driven directly by the stimulus.
module tb_xalu_ise_issue;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    xalu_ise_issue_if bus1();
    xalu_ise_issue_if bus3();

`ifdef XALU_ISE_ISSUE_PERF_EN
    logic [31:0] perf_ops1, perf_ill1, perf_ops3, perf_ill3;
`endif

    xalu_ise_issue #(.EXEC_CYCLES(1)) dut1 (
        .ise_clk      (clk),
        .ise_rst      (rst),
        .bus          (bus1.slave)
`ifdef XALU_ISE_ISSUE_PERF_EN
        ,
        .perf_ops     (perf_ops1),
        .perf_illegal (perf_ill1)
`endif
    );

    xalu_ise_issue #(.EXEC_CYCLES(3)) dut3 (
        .ise_clk      (clk),
        .ise_rst      (rst),
        .bus          (bus3.slave)
`ifdef XALU_ISE_ISSUE_PERF_EN
        ,
        .perf_ops     (perf_ops3),
        .perf_illegal (perf_ill3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: rotate rs1 right by funct7[4:0]; funct7[6]=1 is unclaimed
    always_comb begin
        bus1.ise_oval = bus1.ise_val && !bus1.ise_imm[6];
        bus1.ise_out  = 32'd0;
        if (bus1.ise_val)
            bus1.ise_out = (bus1.ise_in1 >> bus1.ise_imm[4:0]) |
                           (bus1.ise_in1 << (6'd32 - {1'b0, bus1.ise_imm[4:0]}));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    // both request tasks start at a negedge and return at the first negedge after acceptance
    task automatic req1(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        bus1.req_valid = 1'b1; bus1.req_instr = instr; bus1.req_rs1 = rs1; bus1.req_rs2 = rs2;
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic req3(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        bus3.req_valid = 1'b1; bus3.req_instr = instr; bus3.req_rs1 = rs1; bus3.req_rs2 = rs2;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic [31:0] i_rot, i_nc, i_c2, i_c1, i_c3;
        i_rot = {7'b0000101, 5'd0, 5'd0, 3'b001, 5'd3,  7'b0001011};
        i_nc  = {7'b0000000, 5'd0, 5'd0, 3'b000, 5'd9,  7'b0110011};
        i_c2  = {7'b0000100, 5'd0, 5'd0, 3'b010, 5'd17, 7'b1011011};
        i_c1  = {7'b1100000, 5'd0, 5'd0, 3'b000, 5'd5,  7'b0101011};
        i_c3  = {7'b0000001, 5'd0, 5'd0, 3'b000, 5'd7,  7'b1111011};

        rst = 1'b1;
        bus1.req_valid = 0; bus1.req_instr = 0; bus1.req_rs1 = 0; bus1.req_rs2 = 0; bus1.rsp_ready = 0;
        bus3.req_valid = 0; bus3.req_instr = 0; bus3.req_rs1 = 0; bus3.req_rs2 = 0; bus3.rsp_ready = 0;
        bus3.ise_oval = 0; bus3.ise_out = 0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_req_ready", bus1.req_ready, 1);
        chk("rst_rsp_valid", bus1.rsp_valid, 0);
        chk("rst_ise_val",   bus1.ise_val, 0);
        chk("rst_rsp_data",  bus1.rsp_data, 0);
        chk("rst_illegal",   bus1.rsp_illegal, 0);
        chk("rst_ise_fn",    bus1.ise_fn, 0);
        rst = 1'b0;
        @(negedge clk);

        // EXEC_CYCLES=3: only the last EXEC cycle's ise_out counts
        bus3.ise_oval = 1'b1; bus3.ise_out = 32'hDEAD_BEEF;
        req3(i_c3, 32'h0000_00AA, 32'h0000_00BB);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("e3_ise_val_%0d", i), bus3.ise_val, 1);
            chk($sformatf("e3_rsp_valid_%0d", i), bus3.rsp_valid, 0);
            bus3.ise_out = (i == 3) ? 32'h1234_5678 : 32'hCAFE_F00D;
            @(negedge clk);
        end
        chk("e3_rsp_valid", bus3.rsp_valid, 1);
        chk("e3_ise_val_off", bus3.ise_val, 0);
        chk("e3_rsp_data", bus3.rsp_data, 32'h1234_5678);
        chk("e3_illegal",  bus3.rsp_illegal, 0);
        chk("e3_rd",       bus3.rsp_rd, 7);
        chk("e3_fn",       bus3.ise_fn, 6'd3);
        bus3.rsp_ready = 1'b1;
        @(negedge clk);
        bus3.rsp_ready = 1'b0;
        chk("e3_idle_ready", bus3.req_ready, 1);
        chk("e3_idle_valid", bus3.rsp_valid, 0);

        // reset pulse in second EXEC cycle
        req3(i_c3, 32'h5555_5555, 32'h0);
        @(negedge clk);
        chk("rx_ise_val_pre", bus3.ise_val, 1);
        rst = 1'b1;
        #1;
        chk("rx_ise_val",   bus3.ise_val, 0);
        chk("rx_req_ready", bus3.req_ready, 1);
        chk("rx_rsp_valid", bus3.rsp_valid, 0);
        chk("rx_ise_in1",   bus3.ise_in1, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus3.rsp_valid) seen = 1'b1;
        end
        chk("rx_no_rsp", seen, 0);
`ifdef XALU_ISE_ISSUE_PERF_EN
        chk("perf_ops_rst", perf_ops1, 0);
        chk("perf_ill_rst", perf_ill1, 0);
`endif

        // rotate: 1 ror 5
        req1(i_rot, 32'h0000_0001, 32'h0);
        chk("rot_ise_val",   bus1.ise_val, 1);
        chk("rot_fn",        bus1.ise_fn, 6'd4);
        chk("rot_imm",       bus1.ise_imm, 7'b0000101);
        chk("rot_in1",       bus1.ise_in1, 1);
        chk("rot_rsp_early", bus1.rsp_valid, 0);
        @(negedge clk);
        chk("rot_rsp_valid", bus1.rsp_valid, 1);
        chk("rot_data",      bus1.rsp_data, 32'h0800_0000);
        chk("rot_illegal",   bus1.rsp_illegal, 0);
        chk("rot_rd",        bus1.rsp_rd, 3);
        chk("rot_ise_off",   bus1.ise_val, 0);
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        chk("rot_idle", bus1.req_ready, 1);

        // non-custom opcode
        req1(i_nc, 32'h5, 32'h6);
        chk("nc_ise_val",   bus1.ise_val, 0);
        chk("nc_rsp_valid", bus1.rsp_valid, 1);
        chk("nc_illegal",   bus1.rsp_illegal, 1);
        chk("nc_data",      bus1.rsp_data, 0);
        chk("nc_rd",        bus1.rsp_rd, 9);
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        chk("nc_idle", bus1.rsp_valid, 0);

        // backpressure with a competing request held during RESP
        req1(i_c2, 32'h0000_0010, 32'h0);
        chk("bp_fn", bus1.ise_fn, 6'd10);
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_instr = i_rot; bus1.req_rs1 = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_valid_%0d", i), bus1.rsp_valid, 1);
            chk($sformatf("bp_data_%0d", i),  bus1.rsp_data, 1);
            chk($sformatf("bp_rd_%0d", i),    bus1.rsp_rd, 17);
            chk($sformatf("bp_ready_%0d", i), bus1.req_ready, 0);
            @(negedge clk);
        end
        bus1.req_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        chk("bp_idle_ready", bus1.req_ready, 1);
        chk("bp_idle_valid", bus1.rsp_valid, 0);
        chk("bp_in1_kept",   bus1.ise_in1, 32'h0000_0010);
`ifdef XALU_ISE_ISSUE_PERF_EN
        chk("perf_ops", perf_ops1, 3);
        chk("perf_ill", perf_ill1, 1);
`endif

        // op not claimed by the ALU
        req1(i_c1, 32'h0000_1234, 32'h0);
        chk("unc_ise_val", bus1.ise_val, 1);
        chk("unc_fn",      bus1.ise_fn, 6'd1);
        @(negedge clk);
        chk("unc_rsp_valid", bus1.rsp_valid, 1);
        chk("unc_illegal",   bus1.rsp_illegal, 1);
        chk("unc_data",      bus1.rsp_data, 0);
        chk("unc_rd",        bus1.rsp_rd, 5);
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        chk("unc_idle", bus1.req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xalu_ise_issue.md
Name: xalu_ise_issue

Overview:
- Issue/writeback stage directly upstream of the Alzette/Sparkle custom-instruction ALU (xalu_ise).
- Accepts one decoded custom-opcode request from the RV32 core over a valid/ready handshake and registers the operands.
- Drives the ALU's ise_val/ise_fn/ise_imm/ise_in1/ise_in2 for a fixed number of cycles, captures ise_out/ise_oval, and returns the result to the core's writeback over a second valid/ready handshake.
- Non-custom opcodes, and ops the ALU does not claim, are returned flagged illegal.

Parameters:
- EXEC_CYCLES, 1, cycles ise_val is held high before the result is sampled; legal range 1..15.

Ports:
- ise_clk  in  1  clock.
- ise_rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_instr  in  32  raw instruction word.
- req_rs1  in  32  rs1 value.
- req_rs2  in  32  rs2 value.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  core accepts result.
- rsp_data  out  32  result value.
- rsp_rd  out  5  destination register, instr[11:7].
- rsp_illegal  out  1  op not executed or not claimed by the ALU.
- ise_val  out  1  ALU operation valid.
- ise_fn  out  6  {1'b0, funct3, custom index[1:0]}.
- ise_imm  out  7  funct7, instr[31:25].
- ise_in1  out  32  registered rs1.
- ise_in2  out  32  registered rs2.
- ise_oval  in  1  ALU claimed the operation.
- ise_out  in  32  ALU result.

Behaviour:
- Clocking: one clock, ise_clk. ise_rst is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0, except req_ready=1.
- Opcode decode, instr[6:0]:
  - 0001011 -> index 0 (custom-0).
  - 0101011 -> index 1 (custom-1).
  - 1011011 -> index 2 (custom-2).
  - 1111011 -> index 3 (custom-3).
  - Anything else is non-custom.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch rs1, rs2, funct7, funct3, index and rd.
  - Custom opcode -> EXEC, with the cycle counter loaded to EXEC_CYCLES-1.
  - Non-custom opcode -> RESP with rsp_illegal=1 and rsp_data=0; ise_val is never asserted for it.
- EXEC:
  - req_ready=0; ise_val=1; operand outputs are stable from registers.
  - Counter decrements each cycle.
  - When the counter is 0: capture rsp_data = ise_oval ? ise_out : 0 and rsp_illegal = ~ise_oval, then go to RESP.
  - ise_val is high for exactly EXEC_CYCLES consecutive cycles.
- RESP:
  - rsp_valid=1; rsp_data, rsp_rd and rsp_illegal are held stable.
  - When rsp_ready=1 -> IDLE.
  - req_ready=0 throughout, so no overlap with the next request.
- Latency, measured from the accepting edge:
  - Custom op: rsp_valid rises EXEC_CYCLES+1 cycles later.
  - Non-custom op: rsp_valid rises 1 cycle later.
- Throughput:
  - One op every EXEC_CYCLES+2 cycles when rsp_ready is tied high.
  - A non-custom op takes 2 cycles.
- ise_val=0 in IDLE and RESP. ise_in1/ise_in2/ise_fn/ise_imm keep their last values outside EXEC.
- Reset asserted mid-EXEC or mid-RESP: the in-flight op is dropped with no response, and outputs immediately return to reset values.
- req_valid is ignored outside IDLE.
- rsp_ready asserted without rsp_valid has no effect.

Optional Feature:
- Macro: XALU_ISE_ISSUE_PERF_EN.
- Defined:
  - Adds ports perf_ops (out, 32) and perf_illegal (out, 32).
  - perf_ops increments on each response handshake; perf_illegal increments on each handshake with rsp_illegal=1.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Custom opcode constants, OPC_CUSTOM0..3.
  - Custom index localparams CUSTOM_0..3.
  - FSM state encoding ST_IDLE, ST_EXEC, ST_RESP.
- Natural sub-module: xalu_ise_issue_dec, a combinational opcode-to-index/legal decoder.
- xalu_ise is instantiated by the parent, not inside this block.

Test Plan:
- Rotate: custom-0, funct7=0000101, rs1=0x00000001, EXEC_CYCLES=1 (xalu_ise attached) -> ise_val high 1 cycle, ise_fn[1:0]=00, ise_imm=0000101; 2 cycles later rsp_valid, rsp_data=0x08000000, rsp_illegal=0.
- Non-custom: instr opcode 0110011 -> ise_val never high; rsp_valid next cycle with rsp_illegal=1, rsp_data=0, rsp_rd=instr[11:7].
- Unclaimed: custom-1, funct7=1100000 (ise_oval=0) -> rsp_illegal=1, rsp_data=0.
- Backpressure: rsp_ready held low 3 cycles in RESP -> rsp_data/rsp_rd stable, req_ready=0, a second req_valid is not accepted; after rsp_ready=1, back to IDLE next cycle.
- EXEC_CYCLES=3: ise_val high exactly 3 cycles; rsp_valid on cycle 4 after the accepting edge; ise_out changed before the last EXEC cycle does not affect the result (only the final EXEC cycle is sampled).
- Reset pulse in the second EXEC cycle -> ise_val=0, req_ready=1 immediately, no rsp_valid; with XALU_ISE_ISSUE_PERF_EN defined the counters read 0, and after 2 legal ops plus 1 illegal op perf_ops=3, perf_illegal=1.
